// File: rtl/n64_poll_sched.sv
// n64_poll_sched: issues periodic status/poll transactions on the N64 link,
// with response timeout and retry, and latches buttons, controller ID and errors.
module n64_poll_sched #(
    parameter int unsigned POLL_PERIOD = 500000,
    parameter int unsigned TIMEOUT     = 10000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [15:0] CTRL_ID     = 16'h0500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        tx_go,
    output logic [7:0]  tx_cmd,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic [31:0] buttons,
    output logic        buttons_valid,
    output logic [15:0] ctrl_id,
    output logic        present,
    output logic [7:0]  err_cnt,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_PERIOD, S_ISSUE, S_WAIT_RESP} state_t;
    state_t      r_state;
    logic [31:0] r_period_cnt;
    logic [31:0] r_timeout_cnt;
    logic [31:0] r_retry;
    logic [15:0] w_rx_id;
    assign w_rx_id = rx_data[23:8];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_period_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_retry       <= '0;
            tx_go         <= 1'b0;
            tx_cmd        <= 8'h00;
            buttons       <= '0;
            buttons_valid <= 1'b0;
            ctrl_id       <= '0;
            present       <= 1'b0;
            err_cnt       <= '0;
            busy          <= 1'b0;
        end else begin
            tx_go         <= 1'b0;
            buttons_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (enable) begin
                    r_period_cnt <= '0;
                    r_state      <= S_WAIT_PERIOD;
                end
                S_WAIT_PERIOD: if (!enable) begin
                    r_state <= S_IDLE;
                end else if (r_period_cnt == POLL_PERIOD - 1) begin
                    r_retry <= '0;
                    tx_cmd  <= present ? 8'h01 : 8'h00;
                    busy    <= 1'b1;
                    r_state <= S_ISSUE;
                end else begin
                    r_period_cnt <= r_period_cnt + 32'd1;
                end
                S_ISSUE: begin
                    tx_go         <= 1'b1;
                    r_timeout_cnt <= '0;
                    r_state       <= S_WAIT_RESP;
                end
                S_WAIT_RESP: if (rx_valid) begin
                    // a response on the timeout cycle still counts as success
                    if (tx_cmd == 8'h01) begin
                        buttons       <= rx_data;
                        buttons_valid <= 1'b1;
                    end else begin
                        ctrl_id <= w_rx_id;
                        present <= (w_rx_id == CTRL_ID);
                    end
                    busy         <= 1'b0;
                    r_period_cnt <= '0;
                    r_state      <= S_WAIT_PERIOD;
                end else if (r_timeout_cnt == TIMEOUT - 1) begin
                    r_retry <= r_retry + 32'd1;
                    if (r_retry + 32'd1 < MAX_RETRY) begin
                        r_state <= S_ISSUE;
                    end else begin
                        present      <= 1'b0;
                        err_cnt      <= (err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
                        busy         <= 1'b0;
                        r_period_cnt <= '0;
                        r_state      <= S_WAIT_PERIOD;
                    end
                end else begin
                    r_timeout_cnt <= r_timeout_cnt + 32'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
